// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter:
//   - arb_state_e : sequencer state encoding (IDLE/BUSY/RESP)
//   - PORT_I/PORT_D : requester indices (instruction side, data side)
//   - RD/WR : memory request direction encoding
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int unsigned PORT_I = 0;
  localparam int unsigned PORT_D = 1;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin picker.
//   req_i[1:0]    : request lines, bit N = port N
//   last_grant_i  : index of the port granted most recently
//   grant_o[1:0]  : one-hot winner, zero when nothing requests
// A lone requester always wins; on a tie the port that was not granted
// last time wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer sharing the single main-memory port between the
// instruction-side requester (port 0) and the data-side requester (port 1).
// Ports:
//   CLK, RESETn            : clock (rising edge), async active-low reset
//   rqN_req_valid/rw/addr  : request from port N, held until rqN_ready
//   rqN_data_write         : write data from port N
//   rqN_data_read          : registered read data returned to port N
//   rqN_ready, rqN_err     : one-cycle completion pulse, err on abort
//   mem_req_valid/rw/addr  : registered memory request
//   mem_data_write         : registered memory write data
//   mem_data_read          : memory read data, valid with mem_ready
//   mem_ready              : memory completion, sampled only while BUSY
//   grant                  : one-hot owner of the memory port
//   busy                   : sequencer not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              rq0_req_valid,
  input  logic              rq0_req_rw,
  input  logic [ADDR_W-1:0] rq0_req_addr,
  input  logic [DATA_W-1:0] rq0_data_write,
  output logic [DATA_W-1:0] rq0_data_read,
  output logic              rq0_ready,
  output logic              rq0_err,
  input  logic              rq1_req_valid,
  input  logic              rq1_req_rw,
  input  logic [ADDR_W-1:0] rq1_req_addr,
  input  logic [DATA_W-1:0] rq1_data_write,
  output logic [DATA_W-1:0] rq1_data_read,
  output logic              rq1_ready,
  output logic              rq1_err,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_data_write,
  input  logic [DATA_W-1:0] mem_data_read,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]    ADDR_MSK = ~ADDR_W'(3);

  arb_state_e               state_q, state_d;
  logic                     last_q, last_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               grant_q, grant_d;
  logic                     mvalid_q, mvalid_d;
  logic                     mrw_q, mrw_d;
  logic [ADDR_W-1:0]        maddr_q, maddr_d;
  logic [DATA_W-1:0]        mwdata_q, mwdata_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]               ready_q, ready_d;
  logic [1:0]               err_q, err_d;

  logic [1:0]               req_v;
  logic [1:0]               arb_gnt;
  logic                     owner;
  logic                     sel_rw;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;

  assign req_v = {rq1_req_valid, rq0_req_valid};
  assign owner = grant_q[1];

  rr_arbiter2 u_rr (
    .req_i        (req_v),
    .last_grant_i (last_q),
    .grant_o      (arb_gnt)
  );

  // Payload of whichever port the picker selected this cycle.
  always_comb begin
    sel_rw    = arb_gnt[1] ? rq1_req_rw     : rq0_req_rw;
    sel_addr  = arb_gnt[1] ? rq1_req_addr   : rq0_req_addr;
    sel_wdata = arb_gnt[1] ? rq1_data_write : rq0_data_write;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      grant_q  <= '0;
      mvalid_q <= 1'b0;
      mrw_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      ready_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      mvalid_q <= mvalid_d;
      mrw_q    <= mrw_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    mvalid_d = mvalid_q;
    mrw_d    = mrw_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    ready_d  = '0;
    err_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_v) begin
          grant_d  = arb_gnt;
          last_d   = arb_gnt[1];
          mvalid_d = 1'b1;
          mrw_d    = sel_rw;
          maddr_d  = sel_addr & ADDR_MSK;
          mwdata_d = sel_wdata;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Completion is checked first so a reply in the final cycle wins
        // over the abort.
        if (mem_ready) begin
          mvalid_d = 1'b0;
          if (mrw_q == RD) rdata_d[owner] = mem_data_read;
          ready_d  = grant_q;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          mvalid_d = 1'b0;
          if (mrw_q == RD) rdata_d[owner] = '0;
          ready_d  = grant_q;
          err_d    = grant_q;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        cnt_d   = '0;
        grant_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rq0_data_read  = rdata_q[PORT_I];
  assign rq1_data_read  = rdata_q[PORT_D];
  assign rq0_ready      = ready_q[PORT_I];
  assign rq1_ready      = ready_q[PORT_D];
  assign rq0_err        = err_q[PORT_I];
  assign rq1_err        = err_q[PORT_D];
  assign mem_req_valid  = mvalid_q;
  assign mem_req_rw     = mrw_q;
  assign mem_req_addr   = maddr_q;
  assign mem_data_write = mwdata_q;
  assign grant          = grant_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 256;

  logic              CLK;
  logic              RESETn;
  logic              rq0_req_valid, rq0_req_rw;
  logic [ADDR_W-1:0] rq0_req_addr;
  logic [DATA_W-1:0] rq0_data_write, rq0_data_read;
  logic              rq0_ready, rq0_err;
  logic              rq1_req_valid, rq1_req_rw;
  logic [ADDR_W-1:0] rq1_req_addr;
  logic [DATA_W-1:0] rq1_data_write, rq1_data_read;
  logic              rq1_ready, rq1_err;
  logic              mem_req_valid, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_data_write, mem_data_read;
  logic              mem_ready;
  logic [1:0]        grant;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_gnt [12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
  int exp_r0  [12] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int exp_r1  [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .RESETn         (RESETn),
    .rq0_req_valid  (rq0_req_valid),
    .rq0_req_rw     (rq0_req_rw),
    .rq0_req_addr   (rq0_req_addr),
    .rq0_data_write (rq0_data_write),
    .rq0_data_read  (rq0_data_read),
    .rq0_ready      (rq0_ready),
    .rq0_err        (rq0_err),
    .rq1_req_valid  (rq1_req_valid),
    .rq1_req_rw     (rq1_req_rw),
    .rq1_req_addr   (rq1_req_addr),
    .rq1_data_write (rq1_data_write),
    .rq1_data_read  (rq1_data_read),
    .rq1_ready      (rq1_ready),
    .rq1_err        (rq1_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_data_write (mem_data_write),
    .mem_data_read  (mem_data_read),
    .mem_ready      (mem_ready),
    .grant          (grant),
    .busy           (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, " mem_req_addr"},  64'(mem_req_addr),  64'd0);
    check({tag, " grant"},         64'(grant),         64'd0);
    check({tag, " busy"},          64'(busy),          64'd0);
    check({tag, " rq0_ready"},     64'(rq0_ready),     64'd0);
    check({tag, " rq1_ready"},     64'(rq1_ready),     64'd0);
    check({tag, " rq0_data_read"}, 64'(rq0_data_read), 64'd0);
    check({tag, " rq1_data_read"}, 64'(rq1_data_read), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    RESETn = 1'b0;
    rq0_req_valid = 0; rq0_req_rw = 0; rq0_req_addr = '0; rq0_data_write = '0;
    rq1_req_valid = 0; rq1_req_rw = 0; rq1_req_addr = '0; rq1_data_write = '0;
    mem_data_read = '0; mem_ready = 0;
    repeat (3) tick();
    check_all_zero("reset");
    RESETn = 1'b1;
    tick();

    // Port 0 read, reply 3 cycles after mem_req_valid.
    rq0_req_valid = 1; rq0_req_rw = 0; rq0_req_addr = 32'h0000_0043;
    tick();
    check("t1 mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("t1 mem_req_addr",  64'(mem_req_addr),  64'h40);
    check("t1 mem_req_rw",    64'(mem_req_rw),    64'd0);
    check("t1 grant",         64'(grant),         64'd1);
    check("t1 busy",          64'(busy),          64'd1);
    tick(); tick();
    check("t1 held valid",    64'(mem_req_valid), 64'd1);
    check("t1 no early rdy",  64'(rq0_ready),     64'd0);
    tick();
    mem_ready = 1; mem_data_read = 32'hDEAD_BEEF;
    tick();
    mem_ready = 0; rq0_req_valid = 0;
    check("t1 rq0_ready",     64'(rq0_ready),     64'd1);
    check("t1 rq0_err",       64'(rq0_err),       64'd0);
    check("t1 rq0_data_read", 64'(rq0_data_read), 64'hDEAD_BEEF);
    check("t1 mem_valid off", 64'(mem_req_valid), 64'd0);
    check("t1 rq1_ready",     64'(rq1_ready),     64'd0);
    check("t1 rq1_data_read", 64'(rq1_data_read), 64'd0);
    tick();
    check("t1 rdy pulse end", 64'(rq0_ready),     64'd0);
    check("t1 idle busy",     64'(busy),          64'd0);
    check("t1 idle grant",    64'(grant),         64'd0);

    // Tie right after reset: port 0 first, then port 1 write.
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    rq0_req_valid = 1; rq0_req_rw = 0; rq0_req_addr = 32'h100;
    rq1_req_valid = 1; rq1_req_rw = 1; rq1_req_addr = 32'h2000; rq1_data_write = 32'h1234_5678;
    tick();
    check("t2 grant p0",      64'(grant),         64'd1);
    check("t2 addr p0",       64'(mem_req_addr),  64'h100);
    check("t2 rw p0",         64'(mem_req_rw),    64'd0);
    mem_ready = 1; mem_data_read = 32'hCAFE_F00D;
    tick();
    mem_ready = 0; rq0_req_valid = 0;
    check("t2 rq0_ready",     64'(rq0_ready),     64'd1);
    check("t2 rq0_data",      64'(rq0_data_read), 64'hCAFE_F00D);
    check("t2 rq1 idle rdy",  64'(rq1_ready),     64'd0);
    tick();
    check("t2 M+2 idle",      64'(busy),          64'd0);
    check("t2 M+2 no valid",  64'(mem_req_valid), 64'd0);
    tick();
    check("t2 M+3 valid",     64'(mem_req_valid), 64'd1);
    check("t2 M+3 grant",     64'(grant),         64'd2);
    check("t2 M+3 rw",        64'(mem_req_rw),    64'd1);
    check("t2 M+3 addr",      64'(mem_req_addr),  64'h2000);
    check("t2 M+3 wdata",     64'(mem_data_write), 64'h1234_5678);
    mem_ready = 1; mem_data_read = 32'h5555_5555;
    tick();
    mem_ready = 0; rq1_req_valid = 0;
    check("t2 rq1_ready",     64'(rq1_ready),     64'd1);
    check("t2 rq1 data kept", 64'(rq1_data_read), 64'd0);
    check("t2 rq0 data kept", 64'(rq0_data_read), 64'hCAFE_F00D);
    tick();

    // Continuous requests from both ports with a 1-cycle memory.
    rq0_req_valid = 1; rq0_req_rw = 0; rq0_req_addr = 32'h10;
    rq1_req_valid = 1; rq1_req_rw = 0; rq1_req_addr = 32'h20;
    mem_ready = 1; mem_data_read = 32'h0BAD_F00D;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t3 grant c%0d", i), 64'(grant),     64'(exp_gnt[i]));
      check($sformatf("t3 rdy0 c%0d", i),  64'(rq0_ready), 64'(exp_r0[i]));
      check($sformatf("t3 rdy1 c%0d", i),  64'(rq1_ready), 64'(exp_r1[i]));
    end
    rq0_req_valid = 0; rq1_req_valid = 0; mem_ready = 0;
    check("t3 rq0 data", 64'(rq0_data_read), 64'h0BAD_F00D);
    check("t3 rq1 data", 64'(rq1_data_read), 64'h0BAD_F00D);
    tick();
    check("t3 idle", 64'(busy), 64'd0);

    // Timeout abort on a port 1 read.
    rq1_req_valid = 1; rq1_req_rw = 0; rq1_req_addr = 32'h3000;
    tick();
    cnt = 0;
    while (mem_req_valid === 1'b1 && cnt < 300) begin
      if (rq1_ready !== 1'b0) check("t4 early ready", 64'(rq1_ready), 64'd0);
      cnt++;
      tick();
    end
    check("t4 busy cycles",  64'(cnt),           64'd256);
    check("t4 rq1_ready",    64'(rq1_ready),     64'd1);
    check("t4 rq1_err",      64'(rq1_err),       64'd1);
    check("t4 rq1 data zero", 64'(rq1_data_read), 64'd0);
    check("t4 rq0_ready",    64'(rq0_ready),     64'd0);
    check("t4 rq0 data kept", 64'(rq0_data_read), 64'h0BAD_F00D);
    rq1_req_valid = 0;
    mem_ready = 1; mem_data_read = 32'h9999_9999;
    tick();
    check("t4 err pulse end", 64'(rq1_err),      64'd0);
    check("t4 late ready",   64'(rq1_ready),     64'd0);
    check("t4 idle",         64'(busy),          64'd0);
    tick();
    check("t4 late no req",  64'(mem_req_valid), 64'd0);
    check("t4 late data",    64'(rq1_data_read), 64'd0);
    mem_ready = 0;

    // Reply in the final BUSY cycle wins over the abort.
    rq0_req_valid = 1; rq0_req_rw = 0; rq0_req_addr = 32'h44;
    tick();
    repeat (255) tick();
    check("t5 still busy",   64'(mem_req_valid), 64'd1);
    mem_ready = 1; mem_data_read = 32'hA5A5_5A5A;
    tick();
    mem_ready = 0; rq0_req_valid = 0;
    check("t5 rq0_ready",    64'(rq0_ready),     64'd1);
    check("t5 rq0_err",      64'(rq0_err),       64'd0);
    check("t5 rq0 data",     64'(rq0_data_read), 64'hA5A5_5A5A);
    tick();

    // Reset in the middle of BUSY, then tie must go to port 0.
    rq0_req_valid = 1; rq0_req_rw = 1; rq0_req_addr = 32'h80; rq0_data_write = 32'h77;
    tick();
    tick();
    check("t6 busy before",  64'(busy),          64'd1);
    #2;
    RESETn = 1'b0;
    #1;
    check_all_zero("t6 async reset");
    rq0_req_valid = 0;
    tick();
    RESETn = 1'b1;
    tick();
    check("t6 no ready",     64'(rq0_ready),     64'd0);
    check("t6 idle",         64'(busy),          64'd0);
    rq0_req_valid = 1; rq0_req_rw = 0; rq0_req_addr = 32'h90;
    rq1_req_valid = 1; rq1_req_rw = 0; rq1_req_addr = 32'hA0;
    tick();
    check("t6 tie grant p0", 64'(grant),         64'd1);
    check("t6 tie addr",     64'(mem_req_addr),  64'h90);
    mem_ready = 1; mem_data_read = 32'h1111_2222;
    tick();
    rq0_req_valid = 0; mem_ready = 0;
    check("t6 rq0_ready",    64'(rq0_ready),     64'd1);
    tick();
    tick();
    check("t6 p1 grant",     64'(grant),         64'd2);
    mem_ready = 1; mem_data_read = 32'h3333_4444;
    tick();
    rq1_req_valid = 0; mem_ready = 0;
    check("t6 rq1_ready",    64'(rq1_ready),     64'd1);
    check("t6 rq1 data",     64'(rq1_data_read), 64'h3333_4444);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single main-memory port behind the caches. It shares the memory valid/rw/addr/ready handshake between the instruction-side requester (port 0) and the data-side requester (port 1), using round-robin arbitration. Each granted transaction is held until the memory completes it, and a watchdog aborts transactions the memory never answers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- TIMEOUT, 256, maximum BUSY cycles before abort (≥2)
- CLK  in  1  clock, rising edge
- RESETn  in  1  reset; asynchronous and active-low
- rqN_req_valid  in  1  request from port N (N=0,1); held until rqN_ready
- rqN_req_rw  in  1  0=read, 1=write
- rqN_req_addr  in  ADDR_W  word address; bits [1:0] forced to 0 on issue
- rqN_data_write  in  DATA_W  write data
- rqN_data_read  out  DATA_W  registered read data
- rqN_ready  out  1  one-cycle completion pulse
- rqN_err  out  1  one-cycle pulse with rqN_ready on timeout abort
- mem_req_valid  out  1  memory request, registered
- mem_req_rw  out  1  registered rw
- mem_req_addr  out  ADDR_W  registered address
- mem_data_write  out  DATA_W  registered write data
- mem_data_read  in  DATA_W  memory read data; valid while mem_ready=1
- mem_ready  in  1  memory completion; sampled only in BUSY
- grant  out  2  one-hot owner of the memory port; 0 in IDLE
- busy  out  1  state != IDLE

## Operation
- Reset behaviour (asynchronous, RESETn=0):
  - all outputs 0; state IDLE; last_grant=1, so port 0 wins the first tie; timeout counter 0.
- States are IDLE, BUSY and RESP.
- IDLE:
  - If any rqN_req_valid is high, pick the winner, latch its rw/addr/data into the mem_* registers, and set mem_req_valid=1 and grant.
  - Go to BUSY.
- Arbitration:
  - Single requester wins.
  - On a tie, the port other than last_grant wins.
  - last_grant updates on every grant.
- BUSY:
  - mem_* outputs are held stable.
  - mem_ready=1: mem_req_valid<=0; read data is latched into the owner's rqN_data_read for reads only; go to RESP with err=0.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1: mem_req_valid<=0, owner's rqN_data_read<=0 for reads, go to RESP with err=1.
  - If mem_ready arrives in the same cycle as the timeout, normal completion wins.
- RESP:
  - Owner's rqN_ready=1 (and rqN_err if aborted) for exactly one cycle.
  - Counter clears, grant clears, go to IDLE.
  - Request inputs are not sampled in RESP.
- Writes leave rqN_data_read unchanged.
- The non-owner's outputs never change during another port's transaction.
- A late mem_ready after an abort is ignored.
- Requester rule: valid and payload stay stable until the ready pulse, and valid drops no later than the cycle after it. Violating this is a bench error.

## Timing
- A request sampled high in IDLE at cycle T gives mem_req_valid=1 from cycle T+1.
- mem_ready high in cycle M (M≥T+1) gives rqN_ready/data in M+1; IDLE in M+2.
- Minimum round trip is 2 cycles (mem_ready in T+1, rqN_ready in T+2).
- Back-to-back: next grant is sampled in M+2, next mem_req_valid in M+3.
- Abort: BUSY lasts exactly TIMEOUT cycles (T+1 .. T+TIMEOUT); rqN_ready+err in T+TIMEOUT+1.
- RESETn asserted mid-transaction clears everything immediately; no ready pulse is issued; the memory-side transaction is abandoned.

## Structure
- Package mem_arb_pkg:
  - state encoding (IDLE=0, BUSY=1, RESP=2)
  - port index constants PORT_I=0, PORT_D=1
  - rw constants RD=0, WR=1
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req[1:0] and last_grant, producing a one-hot grant.
- The counter width is $clog2(TIMEOUT).

## Test plan
- Port 0 read at 0x00000043, mem_ready 3 cycles after mem_req_valid with data 0xDEADBEEF -> mem_req_addr=0x00000040, rw=0; rq0_ready pulses one cycle after mem_ready with rq0_data_read=0xDEADBEEF; rq1 outputs stay 0.
- Tie right after reset: port 0 read 0x100 and port 1 write 0x2000/0x12345678 -> port 0 is served first; port 1 gets mem_req_valid at M+3 with rw=1 and mem_data_write=0x12345678; rq1_data_read is unchanged.
- Both ports requesting continuously with 1-cycle memory -> grants alternate 0,1,0,1; each port gets rqN_ready every 6 cycles.
- mem_ready never asserted, TIMEOUT=256 -> mem_req_valid high for exactly 256 cycles; rq1_ready and rq1_err pulse together; rq1_data_read=0 for a read.
- mem_ready in the 256th BUSY cycle -> normal completion with err=0 and data latched.
- RESETn low in the middle of BUSY -> all outputs 0 within the same cycle, no ready pulse; after release, a tie grants port 0.
